// File: rtl/lcd_pkg.sv
// lcd_capture shared definitions: panel defaults,
// RGB565 field layout, 32-bit pack positions, FSM states.
package lcd_pkg;
  localparam int H_ACTIVE_DEF = 480;
  localparam int V_ACTIVE_DEF = 272;
  localparam int ADDR_W = 23;
  localparam int R_W = 5;
  localparam int G_W = 6;
  localparam int B_W = 5;
  localparam int PIX_W = R_W + G_W + B_W;
  localparam int R_LSB = 27;
  localparam int G_LSB = 18;
  localparam int B_LSB = 11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LINE = 2'd1,
    ACTIVE    = 2'd2
  } cap_state_t;

  function automatic logic [31:0] pack565(
    input logic [PIX_W-1:0] p
  );
    logic [31:0] w;
    w = '0;
    w[R_LSB +: R_W] = p[PIX_W-1 -: R_W];
    w[G_LSB +: G_W] = p[B_W +: G_W];
    w[B_LSB +: B_W] = p[B_W-1:0];
    return w;
  endfunction
endpackage

// File: rtl/lcd_pixel_fifo.sv
// pixel_fifo: synchronous write buffer, first-word
// fall-through; a push into a full buffer is taken
// when a pop happens in the same cycle.
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 39
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp];

  // storage array, no reset needed: read is gated by empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/lcd_capture.sv
// lcd_capture: DE-framed RGB565 capture into a
// word-addressed write stream through a small FIFO.
module lcd_capture import lcd_pkg::*; #(
  parameter int          H_ACTIVE   = H_ACTIVE_DEF,
  parameter int          V_ACTIVE   = V_ACTIVE_DEF,
  parameter logic [22:0] BASE_ADDR  = 23'h0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        capture_en,
  input  logic        vid_vsync,
  input  logic        vid_hsync,
  input  logic        vid_de,
  input  logic [4:0]  vid_r,
  input  logic [5:0]  vid_g,
  input  logic [4:0]  vid_b,
  output logic [22:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        wr_enable,
  input  logic        wr_ready,
  input  logic        clear_err,
  output logic        busy,
  output logic        frame_done,
  output logic        line_err,
  output logic        ovf_err
);
  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam int EW = ADDR_W + PIX_W;

  logic             vs_q, vs_prev, de_q, de_prev, en_q;
  logic [PIX_W-1:0] pix_q;
  logic             vs_rise, de_fall;
  cap_state_t       state, nstate;
  logic [XW-1:0]    x, x_n;
  logic [YW-1:0]    y, y_n;
  logic [22:0]      ptr, ptr_n;
  logic             push, lerr_set, done_n, ovf_set;
  logic [EW-1:0]    fdout;
  logic             fempty, ffull;
  logic             unused_hsync;

  assign unused_hsync = vid_hsync;
  assign vs_rise = vs_q && !vs_prev;
  assign de_fall = !de_q && de_prev;

  // single input register stage plus previous-sample edges
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vs_q    <= 1'b0;
      vs_prev <= 1'b0;
      de_q    <= 1'b0;
      de_prev <= 1'b0;
      en_q    <= 1'b0;
      pix_q   <= '0;
    end else begin
      vs_q    <= vid_vsync;
      vs_prev <= vs_q;
      de_q    <= vid_de;
      de_prev <= de_q;
      en_q    <= capture_en;
      pix_q   <= {vid_r, vid_g, vid_b};
    end
  end

  // state, position counters, status flags
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      ptr        <= BASE_ADDR;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      ovf_err    <= 1'b0;
    end else begin
      state      <= nstate;
      x          <= x_n;
      y          <= y_n;
      ptr        <= ptr_n;
      frame_done <= done_n;
      line_err   <= lerr_set | (line_err & ~clear_err);
      ovf_err    <= ovf_set | (ovf_err & ~clear_err);
    end
  end

  // framing: vsync restart has priority over pixel flow
  always_comb begin
    nstate   = state;
    x_n      = x;
    y_n      = y;
    ptr_n    = ptr;
    push     = 1'b0;
    lerr_set = 1'b0;
    done_n   = 1'b0;
    if (vs_rise) begin
      x_n      = '0;
      y_n      = '0;
      ptr_n    = BASE_ADDR;
      nstate   = en_q ? WAIT_LINE : IDLE;
      lerr_set = (state != IDLE);
    end else begin
      unique case (state)
        IDLE: nstate = IDLE;
        WAIT_LINE: begin
          if (de_q) begin
            push   = 1'b1;
            x_n    = x + XW'(1);
            ptr_n  = ptr + 23'd1;
            nstate = ACTIVE;
          end
        end
        ACTIVE: begin
          if (de_q) begin
            if (x == XW'(H_ACTIVE)) begin
              lerr_set = 1'b1;
            end else begin
              push  = 1'b1;
              x_n   = x + XW'(1);
              ptr_n = ptr + 23'd1;
            end
          end else if (de_fall) begin
            lerr_set = (x != XW'(H_ACTIVE));
            x_n      = '0;
            y_n      = y + YW'(1);
            if (y_n == YW'(V_ACTIVE)) begin
              done_n = 1'b1;
              nstate = IDLE;
            end else begin
              nstate = WAIT_LINE;
            end
          end
        end
        default: nstate = IDLE;
      endcase
    end
  end

  assign ovf_set = push && ffull && !(wr_ready && !fempty);
  assign busy    = (state != IDLE);

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .din    ({ptr, pix_q}),
    .pop    (wr_ready),
    .dout   (fdout),
    .empty  (fempty),
    .full   (ffull)
  );

  assign wr_enable = !fempty;
  assign wr_addr   = fempty ? '0 : fdout[EW-1 -: ADDR_W];
  assign wr_data   = fempty ? '0 : pack565(fdout[PIX_W-1:0]);
endmodule

// File: tb/tb_lcd_capture.sv
// Directed bench for lcd_capture on a scaled 8x4 panel
// with a base address that wraps past 2^23.
module tb_lcd_capture;
  localparam int H = 8;
  localparam int V = 4;
  localparam logic [22:0] BASE = 23'h7FFFF0;

  logic        clk, resetn, capture_en;
  logic        vid_vsync, vid_hsync, vid_de;
  logic [4:0]  vid_r;
  logic [5:0]  vid_g;
  logic [4:0]  vid_b;
  logic [22:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_enable, wr_ready, clear_err;
  logic        busy, frame_done, line_err, ovf_err;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  logic [22:0] got_a [$];
  logic [31:0] got_d [$];
  logic [22:0] exp_a [$];
  logic [31:0] exp_d [$];

  lcd_capture #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .capture_en (capture_en),
    .vid_vsync  (vid_vsync),
    .vid_hsync  (vid_hsync),
    .vid_de     (vid_de),
    .vid_r      (vid_r),
    .vid_g      (vid_g),
    .vid_b      (vid_b),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_enable  (wr_enable),
    .wr_ready   (wr_ready),
    .clear_err  (clear_err),
    .busy       (busy),
    .frame_done (frame_done),
    .line_err   (line_err),
    .ovf_err    (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // record accepted writes and frame_done pulses
  always @(negedge clk) begin
    if (resetn && wr_enable && wr_ready) begin
      got_a.push_back(wr_addr);
      got_d.push_back(wr_data);
    end
    if (resetn && frame_done) done_cnt++;
  end

  function automatic logic [15:0] pix(input int x, input int y);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = 5'(x * 3 + y);
    g = 6'(x * 5 + y * 7 + 1);
    b = 5'(31 - x - y);
    return {r, g, b};
  endfunction

  function automatic logic [31:0] pk(input logic [15:0] p);
    return {p[15:11], 3'b000, p[10:5], 2'b00, p[4:0], 11'd0};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_px(input int x, input int y);
    {vid_r, vid_g, vid_b} = pix(x, y);
    vid_de = 1'b1;
  endtask

  task automatic drive_line(input int y, input int x0,
                            input int n, input int gap);
    for (int x = x0; x < n; x++) begin
      drive_px(x, y);
      tick();
    end
    vid_de = 1'b0;
    vid_hsync = 1'b1;
    tick();
    vid_hsync = 1'b0;
    tick(gap - 1);
  endtask

  task automatic vsync_pulse(input logic en);
    capture_en = en;
    vid_vsync = 1'b1;
    tick(2);
    vid_vsync = 1'b0;
    tick(3);
  endtask

  task automatic exp_px(input int off, input int x, input int y);
    exp_a.push_back(BASE + 23'(off));
    exp_d.push_back(pk(pix(x, y)));
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (!wr_enable) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(2);
    n_cmp++;
    if ({wr_enable, busy, frame_done, line_err, ovf_err} !== 5'b0) begin
      n_bad++;
      $display("FAIL rst_flags got %b want 00000",
               {wr_enable, busy, frame_done, line_err, ovf_err});
    end
    n_cmp++;
    if (wr_addr !== 23'h0 || wr_data !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_bus got %h/%h want 0/0", wr_addr, wr_data);
    end
    resetn = 1'b1;
    tick(2);
    n_cmp++;
    if ({wr_enable, busy, line_err, ovf_err} !== 4'b0) begin
      n_bad++;
      $display("FAIL rst_release got %b want 0000",
               {wr_enable, busy, line_err, ovf_err});
    end
  endtask

  task automatic test_frame();
    int gb, d0;
    bit ok;
    gb = got_a.size();
    d0 = done_cnt;
    exp_a.delete();
    exp_d.delete();
    wr_ready = 1'b1;
    vsync_pulse(1'b1);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL frame_busy got %b want 1", busy);
    end
    vid_r = 5'h1F;
    vid_g = 6'h0;
    vid_b = 5'h0;
    vid_de = 1'b1;
    tick();
    drive_px(1, 0);
    n_cmp++;
    if (wr_enable !== 1'b0) begin
      n_bad++;
      $display("FAIL lat_early got %b want 0", wr_enable);
    end
    tick();
    n_cmp++;
    if (wr_enable !== 1'b1 || wr_addr !== BASE ||
        wr_data !== 32'hF800_0000) begin
      n_bad++;
      $display("FAIL lat_px0 got %b %h %h want 1 %h f8000000",
               wr_enable, wr_addr, wr_data, BASE);
    end
    exp_a.push_back(BASE);
    exp_d.push_back(32'hF800_0000);
    for (int x = 1; x < H; x++) exp_px(x, x, 0);
    drive_line(0, 2, H, 4);
    for (int y = 1; y < V; y++) begin
      for (int x = 0; x < H; x++) exp_px(y * H + x, x, y);
      drive_line(y, 0, H, 4);
    end
    drain(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL frame_drain got busy fifo want empty");
    end
    n_cmp++;
    if (got_a.size() - gb !== exp_a.size()) begin
      n_bad++;
      $display("FAIL frame_count got %0d want %0d",
               got_a.size() - gb, exp_a.size());
    end
    for (int i = 0; i < exp_a.size() && gb + i < got_a.size(); i++) begin
      n_cmp++;
      if (got_a[gb+i] !== exp_a[i] || got_d[gb+i] !== exp_d[i]) begin
        n_bad++;
        $display("FAIL frame_wr[%0d] got %h/%h want %h/%h", i,
                 got_a[gb+i], got_d[gb+i], exp_a[i], exp_d[i]);
      end
    end
    n_cmp++;
    if (done_cnt - d0 !== 1 || line_err !== 1'b0 ||
        ovf_err !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL frame_end got done=%0d le=%b oe=%b busy=%b want 1 0 0 0",
               done_cnt - d0, line_err, ovf_err, busy);
    end
  endtask

  task automatic test_overflow();
    int gb, d0;
    bit ok;
    gb = got_a.size();
    d0 = done_cnt;
    exp_a.delete();
    exp_d.delete();
    wr_ready = 1'b1;
    vsync_pulse(1'b1);
    for (int x = 0; x < H; x++) begin
      drive_px(x, 0);
      wr_ready = (x >= 5);
      exp_px(x, x, 0);
      tick();
    end
    vid_de = 1'b0;
    wr_ready = 1'b1;
    tick(6);
    n_cmp++;
    if (ovf_err !== 1'b0) begin
      n_bad++;
      $display("FAIL full_pop_push ovf got %b want 0", ovf_err);
    end
    wr_ready = 1'b0;
    for (int x = 0; x < H; x++) begin
      drive_px(x, 1);
      if (x < 4) exp_px(H + x, x, 1);
      tick();
    end
    vid_de = 1'b0;
    tick(2);
    wr_ready = 1'b1;
    tick(6);
    n_cmp++;
    if (ovf_err !== 1'b1 || line_err !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_set got oe=%b le=%b want 1 0", ovf_err, line_err);
    end
    for (int y = 2; y < V; y++) begin
      for (int x = 0; x < H; x++) exp_px(y * H + x, x, y);
      drive_line(y, 0, H, 4);
    end
    drain(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL ovf_drain got busy fifo want empty");
    end
    n_cmp++;
    if (got_a.size() - gb !== exp_a.size()) begin
      n_bad++;
      $display("FAIL ovf_count got %0d want %0d",
               got_a.size() - gb, exp_a.size());
    end
    for (int i = 0; i < exp_a.size() && gb + i < got_a.size(); i++) begin
      n_cmp++;
      if (got_a[gb+i] !== exp_a[i] || got_d[gb+i] !== exp_d[i]) begin
        n_bad++;
        $display("FAIL ovf_wr[%0d] got %h/%h want %h/%h", i,
                 got_a[gb+i], got_d[gb+i], exp_a[i], exp_d[i]);
      end
    end
    n_cmp++;
    if (done_cnt - d0 !== 1 || ovf_err !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_end got done=%0d oe=%b want 1 1",
               done_cnt - d0, ovf_err);
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    n_cmp++;
    if (ovf_err !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_clear got %b want 0", ovf_err);
    end
  endtask

  task automatic test_line_len();
    int gb, d0;
    bit ok;
    gb = got_a.size();
    d0 = done_cnt;
    exp_a.delete();
    exp_d.delete();
    wr_ready = 1'b1;
    vsync_pulse(1'b1);
    for (int x = 0; x < H - 1; x++) exp_px(x, x, 0);
    drive_line(0, 0, H - 1, 4);
    n_cmp++;
    if (line_err !== 1'b1) begin
      n_bad++;
      $display("FAIL short_line got %b want 1", line_err);
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    for (int x = 0; x < H; x++) exp_px(H - 1 + x, x, 1);
    drive_line(1, 0, H, 4);
    n_cmp++;
    if (line_err !== 1'b0) begin
      n_bad++;
      $display("FAIL good_line got %b want 0", line_err);
    end
    for (int x = 0; x < H; x++) exp_px(2 * H - 1 + x, x, 2);
    drive_line(2, 0, H + 2, 4);
    n_cmp++;
    if (line_err !== 1'b1) begin
      n_bad++;
      $display("FAIL long_line got %b want 1", line_err);
    end
    for (int x = 0; x < H; x++) exp_px(3 * H - 1 + x, x, 3);
    drive_line(3, 0, H, 4);
    drain(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL len_drain got busy fifo want empty");
    end
    n_cmp++;
    if (got_a.size() - gb !== exp_a.size()) begin
      n_bad++;
      $display("FAIL len_count got %0d want %0d",
               got_a.size() - gb, exp_a.size());
    end
    for (int i = 0; i < exp_a.size() && gb + i < got_a.size(); i++) begin
      n_cmp++;
      if (got_a[gb+i] !== exp_a[i] || got_d[gb+i] !== exp_d[i]) begin
        n_bad++;
        $display("FAIL len_wr[%0d] got %h/%h want %h/%h", i,
                 got_a[gb+i], got_d[gb+i], exp_a[i], exp_d[i]);
      end
    end
    n_cmp++;
    if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL len_end got done=%0d busy=%b want 1 0",
               done_cnt - d0, busy);
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
  endtask

  task automatic test_restart();
    int gb, d0;
    bit ok;
    gb = got_a.size();
    d0 = done_cnt;
    exp_a.delete();
    exp_d.delete();
    wr_ready = 1'b1;
    vsync_pulse(1'b1);
    for (int y = 0; y < 2; y++) begin
      for (int x = 0; x < H; x++) exp_px(y * H + x, x, y);
      drive_line(y, 0, H, 4);
    end
    vsync_pulse(1'b1);
    n_cmp++;
    if (line_err !== 1'b1 || busy !== 1'b1 || done_cnt - d0 !== 0) begin
      n_bad++;
      $display("FAIL restart got le=%b busy=%b done=%0d want 1 1 0",
               line_err, busy, done_cnt - d0);
    end
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) exp_px(y * H + x, x, y);
      drive_line(y, 0, H, 4);
    end
    drain(ok);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL rs_drain got busy fifo want empty");
    end
    n_cmp++;
    if (got_a.size() - gb !== exp_a.size()) begin
      n_bad++;
      $display("FAIL rs_count got %0d want %0d",
               got_a.size() - gb, exp_a.size());
    end
    for (int i = 0; i < exp_a.size() && gb + i < got_a.size(); i++) begin
      n_cmp++;
      if (got_a[gb+i] !== exp_a[i] || got_d[gb+i] !== exp_d[i]) begin
        n_bad++;
        $display("FAIL rs_wr[%0d] got %h/%h want %h/%h", i,
                 got_a[gb+i], got_d[gb+i], exp_a[i], exp_d[i]);
      end
    end
    n_cmp++;
    if (done_cnt - d0 !== 1 || line_err !== 1'b1) begin
      n_bad++;
      $display("FAIL rs_end got done=%0d le=%b want 1 1",
               done_cnt - d0, line_err);
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    n_cmp++;
    if (line_err !== 1'b0) begin
      n_bad++;
      $display("FAIL rs_clear got %b want 0", line_err);
    end
  endtask

  task automatic test_reset_mid_line();
    int gb;
    wr_ready = 1'b0;
    vsync_pulse(1'b1);
    for (int x = 0; x < 3; x++) begin
      drive_px(x, 0);
      tick();
    end
    vid_de = 1'b0;
    tick(2);
    gb = got_a.size();
    n_cmp++;
    if (wr_enable !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_held got %b want 1", wr_enable);
    end
    resetn = 1'b0;
    #1;
    n_cmp++;
    if (wr_enable !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_async got en=%b busy=%b want 0 0",
               wr_enable, busy);
    end
    tick(2);
    resetn = 1'b1;
    wr_ready = 1'b1;
    drive_line(0, 3, H, 4);
    vsync_pulse(1'b0);
    n_cmp++;
    if (got_a.size() !== gb || busy !== 1'b0 || wr_enable !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_quiet got writes=%0d busy=%b want 0 0",
               got_a.size() - gb, busy);
    end
    vsync_pulse(1'b1);
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_rearm got %b want 1", busy);
    end
  endtask

  initial begin
    resetn = 1'b0;
    capture_en = 1'b0;
    vid_vsync = 1'b0;
    vid_hsync = 1'b0;
    vid_de = 1'b0;
    vid_r = '0;
    vid_g = '0;
    vid_b = '0;
    wr_ready = 1'b1;
    clear_err = 1'b0;
    test_reset();
    test_frame();
    test_overflow();
    test_line_len();
    test_restart();
    test_reset_mid_line();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
